// File: rtl/uart_pkg.sv
// Shared UART definitions for the transmit path (and any future receive path).
// Holds the 2-bit serializer state encoding, frame constants and line levels.
package uart_pkg;

    typedef logic [1:0] uart_state_t;

    // Kept as plain constants so older tools that choke on enums can still consume them.
    localparam uart_state_t ST_IDLE  = 2'd0;
    localparam uart_state_t ST_START = 2'd1;
    localparam uart_state_t ST_DATA  = 2'd2;
    localparam uart_state_t ST_STOP  = 2'd3;

    localparam int   UART_DATA_BITS  = 8;
    localparam logic UART_IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with first-word-fall-through read data.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   push, wdata     write request and data (ignored when full)
//   pop             read request (ignored when empty); rdata shows the head entry
//   count           occupancy 0..DEPTH
//   full, empty     occupancy flags, decoded from the registered count
module sync_fifo #(
    parameter int   DEPTH = 16,
    parameter int   WIDTH = 8,
    localparam int  AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic [AW:0]      count,
    output logic             full,
    output logic             empty
);

    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == FULL_COUNT);
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rdata   = mem[rptr];

    // Storage needs no reset: entries are only read once count says they were written.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr] <= wdata;
        end
    end

    // DEPTH is a power of two, so the pointers wrap naturally at their width.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                wptr <= wptr + 1'b1;
            end
            if (do_pop) begin
                rptr <= rptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (do_pop && !do_push) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered 8N1 UART transmitter. Bytes are pushed over a valid/ready interface into a FIFO;
// the serializer drains one frame at a time, advancing one bit per clken tick.
// Ports:
//   clk, rst_n   system clock, asynchronous active-low reset
//   clken        one-cycle baud tick per bit period
//   in_valid     in_data holds a byte to enqueue
//   in_data      byte to enqueue
//   in_ready     FIFO can take a byte this cycle
//   tx           serial line, idle high
//   busy         FIFO non-empty or frame in flight
//   count        FIFO occupancy 0..DEPTH
//   overflow     one-cycle pulse after a byte was offered while full
module uart_tx_buffered
    import uart_pkg::*;
#(
    parameter int  DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clken,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        tx,
    output logic        busy,
    output logic [AW:0] count,
    output logic        overflow
);

    uart_state_t state;
    logic [UART_DATA_BITS-1:0] shreg;
    logic [2:0]  bitpos;
    logic        fifo_full;
    logic        fifo_empty;
    logic [7:0]  fifo_rdata;
    logic        push;
    logic        pop;

    // in_ready comes from the pre-pop count, so a full FIFO refuses even on a pop cycle.
    assign in_ready = ~fifo_full;
    assign push     = in_valid & in_ready;
    assign pop      = (state == ST_IDLE) & ~fifo_empty;
    assign busy     = (state != ST_IDLE) | ~fifo_empty;

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .wdata (in_data),
        .rdata (fifo_rdata),
        .count (count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
        end else begin
            overflow <= in_valid & ~in_ready;
        end
    end

    // Serializer: tx only moves on clken, so every level lasts one full bit period.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            shreg  <= '0;
            bitpos <= '0;
            tx     <= UART_IDLE_LEVEL;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pop) begin
                        shreg <= fifo_rdata;
                        state <= ST_START;
                    end
                end
                ST_START: begin
                    if (clken) begin
                        tx     <= 1'b0;
                        bitpos <= '0;
                        state  <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (clken) begin
                        tx <= shreg[bitpos];
                        if (bitpos == 3'(UART_DATA_BITS - 1)) begin
                            state <= ST_STOP;
                        end else begin
                            bitpos <= bitpos + 3'd1;
                        end
                    end
                end
                default: begin
                    if (clken) begin
                        tx    <= UART_IDLE_LEVEL;
                        state <= ST_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Scoreboard bench for uart_tx_buffered: stimulus queues expected bytes, a line monitor
// decodes frames on each baud tick and compares them against the queue.
module tb_uart_tx_buffered;

    logic       clk;
    logic       rst_n;
    logic       clken;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       tx;
    logic       busy;
    logic [4:0] count;
    logic       overflow;

    uart_tx_buffered #(
        .DEPTH (16)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .clken    (clken),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .tx       (tx),
        .busy     (busy),
        .count    (count),
        .overflow (overflow)
    );

    int total = 0;
    int bad   = 0;

    logic [7:0] sb[$];
    int         starts[$];
    logic       txlog[$];
    int         tick_no     = 0;
    int         frames_seen = 0;
    int         ovf_pulses  = 0;
    int         clkdiv      = 0;
    int         mon_nbits   = 0;
    logic       mon_active  = 1'b0;
    logic [7:0] mon_byte    = '0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Baud tick generator; clkdiv == 0 holds clken low.
    initial begin
        int cnt = 0;
        clken = 1'b0;
        forever begin
            @(negedge clk);
            if (clkdiv != 0 && cnt + 1 >= clkdiv) begin
                clken = 1'b1;
                cnt   = 0;
            end else begin
                clken = 1'b0;
                if (clkdiv != 0) cnt++;
            end
        end
    end

    always @(negedge clk) begin
        if (overflow) ovf_pulses++;
    end

    // Line monitor: samples tx just after each ticking edge and decodes 8N1 frames.
    initial begin
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                mon_active = 1'b0;
                mon_nbits  = 0;
                sb.delete();
            end else if (clken) begin
                #1;
                tick_no++;
                txlog.push_back(tx);
                if (!mon_active) begin
                    if (tx == 1'b0) begin
                        mon_active = 1'b1;
                        mon_nbits  = 0;
                        starts.push_back(tick_no);
                    end
                end else if (mon_nbits < 8) begin
                    mon_byte[mon_nbits] = tx;
                    mon_nbits++;
                end else begin
                    check("stop_bit", 32'(tx), 32'd1);
                    if (sb.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_frame: got %0h expected none", mon_byte);
                    end else begin
                        check("frame_byte", 32'(mon_byte), 32'(sb.pop_front()));
                    end
                    frames_seen++;
                    mon_active = 1'b0;
                    mon_nbits  = 0;
                end
            end
        end
    end

    task automatic push_byte(input logic [7:0] b, input logic exp_ready);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        #1;
        check("in_ready", 32'(in_ready), 32'(exp_ready));
        if (exp_ready) sb.push_back(b);
        @(posedge clk);
    endtask

    task automatic end_push();
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int max);
        int n = 0;
        while ((busy || mon_active) && n < max) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(n < max), 32'd1);
    endtask

    initial begin
        int s0;
        int l0;
        int f0;
        int o0;
        int peak;
        int next;
        int guard;
        logic exp1[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        repeat (3) @(negedge clk);
        check("reset_tx", 32'(tx), 32'd1);
        rst_n = 1'b1;
        @(negedge clk);
        check("reset_in_ready", 32'(in_ready), 32'd1);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_count", 32'(count), 32'd0);
        check("reset_overflow", 32'(overflow), 32'd0);

        // Single byte 0x41, tick every 16 clocks.
        clkdiv = 16;
        push_byte(8'h41, 1'b1);
        end_push();
        repeat (2) @(negedge clk);
        l0 = txlog.size();
        wait_idle("single_timeout", 400);
        check("single_ticks", 32'(txlog.size() - l0 >= 10), 32'd1);
        for (int i = 0; i < 10; i++) begin
            if (l0 + i < txlog.size()) check("single_tx_level", 32'(txlog[l0 + i]), 32'(exp1[i]));
        end
        check("single_busy", 32'(busy), 32'd0);
        check("single_count", 32'(count), 32'd0);

        // Back-to-back: three frames must start exactly 10 ticks apart.
        s0   = starts.size();
        peak = 0;
        push_byte(8'h00, 1'b1);
        #1 if (int'(count) > peak) peak = int'(count);
        push_byte(8'hFF, 1'b1);
        #1 if (int'(count) > peak) peak = int'(count);
        push_byte(8'h55, 1'b1);
        #1 if (int'(count) > peak) peak = int'(count);
        end_push();
        check("b2b_peak_ok", 32'(peak == 2 || peak == 3), 32'd1);
        wait_idle("b2b_timeout", 800);
        check("b2b_frames", 32'(starts.size() - s0), 32'd3);
        if (starts.size() - s0 == 3) begin
            check("b2b_gap1", 32'(starts[s0 + 1] - starts[s0]), 32'd10);
            check("b2b_gap2", 32'(starts[s0 + 2] - starts[s0 + 1]), 32'd10);
        end

        // Full/overflow with clken held low. The first byte pops straight into the shift
        // register, so 17 are accepted (1 in flight + 16 queued) and the 18th is refused.
        clkdiv = 0;
        @(negedge clk);
        o0 = ovf_pulses;
        f0 = frames_seen;
        for (int i = 0; i < 18; i++) begin
            push_byte(8'(8'h80 + i), (i < 17) ? 1'b1 : 1'b0);
        end
        end_push();
        repeat (2) @(negedge clk);
        check("full_count", 32'(count), 32'd16);
        check("full_in_ready", 32'(in_ready), 32'd0);
        check("full_ovf_pulses", 32'(ovf_pulses - o0), 32'd1);
        clkdiv = 3;
        wait_idle("full_timeout", 1500);
        check("full_frames", 32'(frames_seen - f0), 32'd17);

        // Push on the pop cycle: count stays at 1.
        clkdiv = 0;
        @(negedge clk);
        push_byte(8'h3C, 1'b1);
        #1 check("pp_count_a", 32'(count), 32'd1);
        push_byte(8'h7E, 1'b1);
        #1 check("pp_count_b", 32'(count), 32'd1);
        end_push();
        clkdiv = 4;
        wait_idle("pp_timeout", 500);

        // Reset during data bit 3 of 0xA5 with four more bytes queued.
        clkdiv = 16;
        push_byte(8'hA5, 1'b1);
        for (int i = 0; i < 4; i++) push_byte(8'(8'h10 + i), 1'b1);
        end_push();
        guard = 0;
        while (mon_nbits < 4 && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        check("rst_reach_bit3", 32'(guard < 2000), 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_tx", 32'(tx), 32'd1);
        check("rst_count", 32'(count), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        f0 = frames_seen;
        s0 = starts.size();
        repeat (300) @(negedge clk);
        check("rst_no_frames", 32'(starts.size() - s0), 32'd0);
        check("rst_no_decoded", 32'(frames_seen - f0), 32'd0);
        check("rst_idle_tx", 32'(tx), 32'd1);

        // Stream 40 bytes gated by in_ready so the pointers wrap.
        clkdiv = 2;
        o0     = ovf_pulses;
        f0     = frames_seen;
        next   = 0;
        guard  = 0;
        while (next < 40 && guard < 5000) begin
            @(negedge clk);
            guard++;
            in_valid = in_ready;
            in_data  = 8'(next);
            if (in_ready) begin
                sb.push_back(8'(next));
                next++;
            end
        end
        end_push();
        check("wrap_all_pushed", 32'(next), 32'd40);
        wait_idle("wrap_timeout", 2000);
        check("wrap_frames", 32'(frames_seen - f0), 32'd40);
        check("wrap_no_overflow", 32'(ovf_pulses - o0), 32'd0);
        check("final_sb_empty", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
